// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and sample-point decode.
// UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around the sample point, strobe one cycle later.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_s_i,
  input  logic                      run_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      sample_bit_o,
  output logic                      sample_stb_o,
  output logic                      bit_wrap_o
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] half;

  assign half       = prescale_i >> 1;
  assign bit_wrap_o = run_i && (edge_cnt_q == (prescale_i - ONE));

  always_comb begin
    edge_cnt_d = edge_cnt_q + ONE;
    if (!run_i || bit_wrap_o) edge_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) edge_cnt_q <= '0;
    else       edge_cnt_q <= edge_cnt_d;
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // hist_q[0] holds the sample point, hist_q[1] the cycle before it
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s_i};
  end

  assign sample_stb_o = run_i && (edge_cnt_q == half);
  assign sample_bit_o = majority3(hist_q[1], hist_q[0], rx_s_i);
`else
  assign sample_stb_o = run_i && (edge_cnt_q == (half - ONE));
  assign sample_bit_o = rx_s_i;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start detect, LSB-first deserialise, optional parity, stop check.
// Optional UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting in the sampler.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [FRAME_WIDTH-1:0]    P_Data,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stp_Err
);

  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] BIT_ONE  = BIT_CNT_WIDTH'(1);

  logic [1:0]                sync_q;
  rx_state_e                 state_q, state_d;
  logic [FRAME_WIDTH-1:0]    shift_q, shift_d;
  logic [FRAME_WIDTH-1:0]    pdata_q, pdata_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      par_fail_q, par_fail_d;
  logic                      dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
  logic                      rx_s, run, sample_bit, sample_stb, bit_wrap;

  assign rx_s = sync_q[1];
  assign run  = (state_q != IDLE);

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .rx_s_i      (rx_s),
    .run_i       (run),
    .prescale_i  (prescale_q),
    .sample_bit_o(sample_bit),
    .sample_stb_o(sample_stb),
    .bit_wrap_o  (bit_wrap)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pdata_d    = pdata_q;
    bit_cnt_d  = bit_cnt_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    dv_d       = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (sample_stb && sample_bit) state_d = IDLE;
        else if (bit_wrap)            state_d = DATA;
      end
      DATA: begin
        if (sample_stb) shift_d = {sample_bit, shift_q[FRAME_WIDTH-1:1]};
        if (bit_wrap) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      PARITY: begin
        if (sample_stb && (sample_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD))))
          par_fail_d = 1'b1;
        if (bit_wrap) state_d = STOP;
      end
      STOP: begin
        // Leave at the stop sample point so a following start bit is not missed
        if (sample_stb) begin
          state_d = IDLE;
          if (!sample_bit)     serr_d = 1'b1;
          else if (par_fail_q) perr_d = 1'b1;
          else begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      par_fail_q <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX_IN};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      par_fail_q <= par_fail_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  // Frame payload and latched configuration need no reset; they are loaded before use
  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    prescale_q <= prescale_d;
    par_en_q   <= par_en_d;
    par_typ_q  <= par_typ_d;
  end

  assign P_Data     = pdata_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = perr_q;
  assign Stp_Err    = serr_q;

endmodule
